gcd_lcm_coproc: RTL
===================

// Module: gcd_lcm_coproc
// PURPOSE
//  Parametrised multicycle GCD/LCM coprocessor attached beside the RISC-V core.
//  Core issues operands plus op via a start/busy/done handshake. Unit computes
//  GCD (binary Stein) and, for LCM, (a/gcd)*b via iterative divide and multiply.
//  Result is held until the next accepted start.
// PARAMETERS
//  XLEN  32  operand/result width in bits (>=4)
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-low (0 = reset)
//  start     in   1        request; accepted only when busy==0
//  op        in   1        0 = GCD, 1 = LCM; sampled with start
//  a_in      in   XLEN     operand A (unsigned); sampled with start
//  b_in      in   XLEN     operand B (unsigned); sampled with start
//  busy      out  1        high from cycle after accept until done cycle inclusive
//  done      out  1        1-cycle pulse; result/ovf valid from this cycle
//  result    out  XLEN     GCD, or low XLEN bits of LCM
//  ovf       out  1        LCM needs more than XLEN bits (always 0 for GCD)
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; busy=0, done=0, result=0, ovf=0.
//  FSM: IDLE -> GCD -> [DIV -> MUL] -> DONE -> IDLE.
//  - IDLE: start==1 latches a_in/b_in/op, clears k, goes to GCD. busy=1 next cycle.
//  - GCD: one step per cycle on regs x,y:
//    x==0 -> g=y<<k; y==0 -> g=x<<k; x==y -> g=x<<k (all exit).
//    Both even: x>>=1, y>>=1, k++. Only x even: x>>=1. Only y even: y>>=1.
//    Both odd: larger := |x-y|.
//    Exit to DONE for op=0, else to DIV. Worst case <= 2*XLEN+2 cycles.
//  - Zero rules: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0. LCM with either operand 0
//    is 0, ovf=0, and skips DIV/MUL (GCD -> DONE).
//  - DIV: restoring divide q=a/g, exactly XLEN cycles. Remainder is always 0.
//  - MUL: shift-add p=q*b into 2*XLEN accumulator, exactly XLEN cycles.
//    result=p[XLEN-1:0], ovf=|p[2*XLEN-1:XLEN].
//  - DONE: done=1, busy=1 for this one cycle; result/ovf updated here.
//    Next cycle goes to IDLE, busy=0.
//  - result/ovf hold their value in IDLE and during computation.
//    They change only in DONE or on reset.
//  - start while busy: ignored (no queue). start in DONE cycle: ignored.
//    A start in the IDLE cycle immediately after DONE is accepted.
//  - Reset mid-operation: abort; all outputs return to reset values next cycle.
//  - Arithmetic: all unsigned. k is $clog2(XLEN)+1 bits. No X on outputs.
// CONFIGURATION
//  GCDLCM_FULLPROD_EN defined:
//    - adds output result_hi [XLEN-1:0] = p[2*XLEN-1:XLEN].
//    - result_hi is 0 for GCD and for zero operands; reset 0; updated in DONE only.
//  GCDLCM_FULLPROD_EN undefined:
//    - no result_hi port; upper product bits reduce only into ovf.
// TESTING (XLEN=32)
//  1. op=0, a=48, b=18 -> done after <=66 cycles; result=6, ovf=0.
//  2. op=1, a=4, b=6 -> result=12, ovf=0. Check busy is high for whole
//     operation and done is exactly 1 cycle.
//  3. Zero cases:
//     op=0, a=0, b=7 -> result=7.
//     op=1, a=0, b=7 -> result=0, ovf=0.
//     op=0, a=0, b=0 -> result=0.
//  4. Overflow: op=1, a=0xFFFFFFFF, b=0xFFFFFFFE -> result=0x00000002, ovf=1.
//     With GCDLCM_FULLPROD_EN: result_hi=0xFFFFFFFD.
//  5. Start while busy:
//     - start op=1 a=12 b=18; pulse start with a=5, b=3 at cycle +5.
//     - Required: single done, result=36; the second start is ignored.
//  6. Reset mid-operation:
//     - start op=1 a=1000 b=999; drive reset=0 at cycle +20.
//     - Required next cycle: busy=0, done=0, result=0, ovf=0.
//     - After release, op=0 a=9 b=6 -> result=3.

Source files
------------

// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: multicycle GCD (binary Stein) / LCM ((a/g)*b) coprocessor.
// Ports: clk, reset (sync, active-low), start/op/a_in/b_in request;
//   busy/done handshake; result, ovf (LCM wider than XLEN).
// Option GCDLCM_FULLPROD_EN adds result_hi (upper half of the LCM product).
module gcd_lcm_coproc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            ovf
`ifdef GCDLCM_FULLPROD_EN
  ,
  output logic [XLEN-1:0] result_hi
`endif
);

  localparam int KW = $clog2(XLEN) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GCD  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [KW-1:0] LASTC = KW'(XLEN - 1);

  logic [2:0]        r_state;
  logic              r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_x;
  logic [XLEN-1:0]   r_y;
  logic [KW-1:0]     r_k;
  logic [XLEN-1:0]   r_g;
  logic [XLEN-1:0]   r_q;
  logic [XLEN-1:0]   r_rem;
  logic [KW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_p;
`ifdef GCDLCM_FULLPROD_EN
  logic [XLEN-1:0]   r_hi;
`endif

  logic              w_gexit;
  logic [XLEN-1:0]   w_gsrc;
  logic [XLEN-1:0]   w_g;
  logic [XLEN:0]     w_rs;
  logic              w_ge;
  logic [XLEN-1:0]   w_rd;
  logic [XLEN-1:0]   w_qn;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_pn;
  logic              w_last;

  // GCD terminates on a zero or equal pair; the survivor carries the answer.
  assign w_gexit = (r_x == '0) | (r_y == '0) | (r_x == r_y);
  assign w_gsrc  = (r_x == '0) ? r_y : r_x;
  assign w_g     = w_gsrc << r_k;

  // Restoring divide: shift next dividend bit into the partial remainder.
  // When it fits, rs - g < g, so the low XLEN bits are exact.
  assign w_rs = {r_rem, r_q[XLEN-1]};
  assign w_ge = w_rs >= {1'b0, r_g};
  assign w_rd = w_rs[XLEN-1:0] - r_g;
  assign w_qn = {r_q[XLEN-2:0], w_ge};

  // Shift-add multiply: multiplier sits in the low half and shifts out
  // while the accumulated sum shifts in from the top.
  assign w_sum = {1'b0, r_p[2*XLEN-1:XLEN]}
               + (r_p[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_pn  = {w_sum, r_p[XLEN-1:1]};

  assign w_last = (r_cnt == LASTC);

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
`ifdef GCDLCM_FULLPROD_EN
  assign result_hi = r_hi;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_g     <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      result  <= '0;
      ovf     <= 1'b0;
`ifdef GCDLCM_FULLPROD_EN
      r_hi    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_x     <= a_in;
            r_y     <= b_in;
            r_op    <= op;
            r_k     <= '0;
            r_state <= S_GCD;
          end
        end
        S_GCD: begin
          if (w_gexit) begin
            if (!r_op || r_a == '0 || r_b == '0) begin
              // LCM with a zero operand is 0 and skips divide/multiply.
              result  <= r_op ? '0 : w_g;
              ovf     <= 1'b0;
`ifdef GCDLCM_FULLPROD_EN
              r_hi    <= '0;
`endif
              r_state <= S_DONE;
            end else begin
              r_g     <= w_g;
              r_q     <= r_a;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_state <= S_DIV;
            end
          end else if (!r_x[0] && !r_y[0]) begin
            r_x <= r_x >> 1;
            r_y <= r_y >> 1;
            r_k <= r_k + KW'(1);
          end else if (!r_x[0]) begin
            r_x <= r_x >> 1;
          end else if (!r_y[0]) begin
            r_y <= r_y >> 1;
          end else if (r_x > r_y) begin
            r_x <= r_x - r_y;
          end else begin
            r_y <= r_y - r_x;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_rd : w_rs[XLEN-1:0];
          r_q   <= w_qn;
          r_cnt <= r_cnt + KW'(1);
          if (w_last) begin
            r_p     <= {{XLEN{1'b0}}, w_qn};
            r_cnt   <= '0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_p   <= w_pn;
          r_cnt <= r_cnt + KW'(1);
          if (w_last) begin
            result  <= w_pn[XLEN-1:0];
            ovf     <= |w_pn[2*XLEN-1:XLEN];
`ifdef GCDLCM_FULLPROD_EN
            r_hi    <= w_pn[2*XLEN-1:XLEN];
`endif
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
